// File: rtl/bp_me_wormhole_endpoint.sv
// bp_me_wormhole_endpoint: ME client <-> wormhole router endpoint, variable-length TX serialiser and RX reassembler; BP_ME_WORMHOLE_LOCAL_BYPASS_EN enables local loopback.
module bp_me_wormhole_endpoint #(
    parameter int x_cord_width_p      = 4,
    parameter int y_cord_width_p      = 4,
    parameter int len_width_p         = 4,
    parameter int max_payload_width_p = 536,
    parameter int flit_width_p        = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [x_cord_width_p-1:0]      my_x_i,
    input  logic [y_cord_width_p-1:0]      my_y_i,
    input  logic [max_payload_width_p-1:0] pkt_i,
    input  logic [x_cord_width_p-1:0]      pkt_x_i,
    input  logic [y_cord_width_p-1:0]      pkt_y_i,
    input  logic [len_width_p-1:0]         pkt_len_i,
    input  logic                           pkt_v_i,
    output logic                           pkt_ready_o,
    output logic [max_payload_width_p-1:0] pkt_o,
    output logic [len_width_p-1:0]         pkt_len_o,
    output logic                           pkt_v_o,
    input  logic                           pkt_ready_i,
    output logic [flit_width_p-1:0]        link_data_o,
    output logic                           link_v_o,
    input  logic                           link_ready_i,
    input  logic [flit_width_p-1:0]        link_data_i,
    input  logic                           link_v_i,
    output logic                           link_ready_o
);
    localparam int cord_width_lp   = x_cord_width_p + y_cord_width_p;
    localparam int hdr_width_lp    = cord_width_lp + len_width_p;
    localparam int packet_width_lp = hdr_width_lp + max_payload_width_p;
    localparam int max_num_flit_lp = (packet_width_lp + flit_width_p - 1) / flit_width_p;
    localparam int buf_width_lp    = max_num_flit_lp * flit_width_p;
    localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_num_flit_lp - 1);

    typedef enum logic {e_tx_idle, e_tx_send} tx_state_e;
    typedef enum logic [1:0] {e_rx_idle, e_rx_recv, e_rx_out} rx_state_e;

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;
    logic [len_width_p-1:0] tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
    logic [len_width_p-1:0] rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
    logic [buf_width_lp-1:0] tx_buf_q, tx_buf_d, rx_buf_q, rx_buf_d, pkt_full;
    logic [len_width_p-1:0] len_clamp, hdr_len, hdr_len_clamp;
    logic tx_last, tx_accept, bypass_go, rx_accept, local_dest, bypass_ok;

`ifdef BP_ME_WORMHOLE_LOCAL_BYPASS_EN
    assign local_dest = (pkt_x_i == my_x_i) && (pkt_y_i == my_y_i);
    // A network header arriving this cycle wins over the local packet
    assign bypass_ok  = (rx_state_q == e_rx_idle) & ~link_v_i;
`else
    logic unused_cord;
    assign local_dest  = 1'b0;
    assign bypass_ok   = 1'b0;
    assign unused_cord = ^{my_x_i, my_y_i};
`endif

    assign len_clamp     = (pkt_len_i > max_len_lp) ? max_len_lp : pkt_len_i;
    assign pkt_full      = buf_width_lp'({pkt_i, len_clamp, pkt_y_i, pkt_x_i});
    assign hdr_len       = link_data_i[cord_width_lp +: len_width_p];
    assign hdr_len_clamp = (hdr_len > max_len_lp) ? max_len_lp : hdr_len;

    assign tx_last     = (tx_state_q == e_tx_send) & link_ready_i & (tx_cnt_q == tx_len_q);
    assign pkt_ready_o = ~reset_i & (local_dest ? bypass_ok : (tx_state_q == e_tx_idle) | tx_last);
    assign tx_accept   = pkt_v_i & pkt_ready_o & ~local_dest;
    assign bypass_go   = pkt_v_i & pkt_ready_o & local_dest;
    assign link_v_o    = (tx_state_q == e_tx_send);
    assign link_data_o = tx_buf_q[tx_cnt_q*flit_width_p +: flit_width_p];

    assign link_ready_o = ~reset_i & (rx_state_q != e_rx_out);
    assign rx_accept    = link_v_i & link_ready_o;
    assign pkt_v_o      = (rx_state_q == e_rx_out);
    assign pkt_o        = rx_buf_q[hdr_width_lp +: max_payload_width_p];
    assign pkt_len_o    = rx_buf_q[cord_width_lp +: len_width_p];

    logic unused_rx;
    assign unused_rx = ^{rx_buf_q[cord_width_lp-1:0], rx_buf_q[buf_width_lp-1:packet_width_lp]};

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_len_d   = tx_len_q;
        tx_buf_d   = tx_buf_q;
        if (tx_accept) begin
            tx_state_d = e_tx_send;
            tx_cnt_d   = '0;
            tx_len_d   = len_clamp;
            tx_buf_d   = pkt_full;
        end else if (tx_last) begin
            tx_state_d = e_tx_idle;
        end else if ((tx_state_q == e_tx_send) && link_ready_i) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_len_d   = rx_len_q;
        rx_buf_d   = rx_buf_q;
        if (bypass_go) begin
            rx_buf_d   = pkt_full;
            rx_state_d = e_rx_out;
        end else if (rx_accept && (rx_state_q == e_rx_idle)) begin
            rx_buf_d   = buf_width_lp'(link_data_i);
            rx_len_d   = hdr_len_clamp;
            rx_cnt_d   = len_width_p'(1);
            rx_state_d = (hdr_len_clamp == '0) ? e_rx_out : e_rx_recv;
        end else if (rx_accept && (rx_state_q == e_rx_recv)) begin
            rx_buf_d[rx_cnt_q*flit_width_p +: flit_width_p] = link_data_i;
            rx_cnt_d   = rx_cnt_q + 1'b1;
            rx_state_d = (rx_cnt_q == rx_len_q) ? e_rx_out : e_rx_recv;
        end else if ((rx_state_q == e_rx_out) && pkt_ready_i) begin
            rx_state_d = e_rx_idle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_q <= e_tx_idle;
            tx_cnt_q   <= '0;
            tx_len_q   <= '0;
            tx_buf_q   <= '0;
            rx_state_q <= e_rx_idle;
            rx_cnt_q   <= '0;
            rx_len_q   <= '0;
            rx_buf_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_len_q   <= tx_len_d;
            tx_buf_q   <= tx_buf_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_len_q   <= rx_len_d;
            rx_buf_q   <= rx_buf_d;
        end
    end

`ifndef SYNTHESIS
    len_legal_a: assert property (@(posedge clk_i) disable iff (reset_i)
        (pkt_v_i & pkt_ready_o) |-> (pkt_len_i <= max_len_lp));
`endif
endmodule

// File: doc/bp_me_wormhole_endpoint.md
Name: bp_me_wormhole_endpoint

Overview:
- Parametrised bidirectional endpoint between a BlackParrot ME client (CCE/LCE side) and one port of a 2D wormhole router.
- TX path: builds a header from destination x/y and a per-packet flit count, then serialises header plus payload into router flits.
- RX path: reassembles incoming flits into a full packet.
- Supports variable-length packets per transfer, so one block serves command, data-command and response networks. This supersedes the fixed-length, per-network router wrappers.

Parameters:
- x_cord_width_p, 4, width of X coordinate.
- y_cord_width_p, 4, width of Y coordinate.
- len_width_p, 4, width of flit-count field; len = number of flits after the header flit.
- max_payload_width_p, 536, widest payload carried.
- flit_width_p, 64, router link width.
- packet_width_lp, derived, x_cord_width_p+y_cord_width_p+len_width_p+max_payload_width_p.
- max_num_flit_lp, derived, ceil(packet_width_lp/flit_width_p); 9 at defaults; must be <= 2^len_width_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- my_x_i  in  x_cord_width_p  local X coordinate.
- my_y_i  in  y_cord_width_p  local Y coordinate.
- pkt_i  in  max_payload_width_p  TX payload.
- pkt_x_i  in  x_cord_width_p  TX destination X.
- pkt_y_i  in  y_cord_width_p  TX destination Y.
- pkt_len_i  in  len_width_p  TX flit count after header.
- pkt_v_i  in  1  TX valid.
- pkt_ready_o  out  1  TX ready.
- pkt_o  out  max_payload_width_p  RX payload.
- pkt_len_o  out  len_width_p  RX length field.
- pkt_v_o  out  1  RX valid.
- pkt_ready_i  in  1  RX ready.
- link_data_o  out  flit_width_p  flit to router.
- link_v_o  out  1  flit valid to router.
- link_ready_i  in  1  router ready.
- link_data_i  in  flit_width_p  flit from router.
- link_v_i  in  1  flit valid from router.
- link_ready_o  out  1  endpoint ready for router flit.

Behaviour:
- Packet format, LSB first: {payload, len, y, x}, with x at bit 0. Flit k = packet bits [k*flit_width_p +: flit_width_p]; the last flit is zero-padded.
- Handshakes: all ports are valid/ready; a transfer occurs when both are high in the same cycle. Valid must not depend combinationally on ready.
- TX FSM, states e_tx_idle and e_tx_send:
  - Accept in e_tx_idle when pkt_v_i&pkt_ready_o: latch the packet, clear flit counter, go to e_tx_send.
  - e_tx_send: link_v_o=1, link_data_o = flit[counter]; counter increments on link_ready_i.
  - When the flit at counter==latched len is accepted, return to e_tx_idle.
  - pkt_ready_o = ~reset_i & (tx_idle | (tx_send & last flit accepted this cycle)). Back-to-back packets therefore run without a bubble; the first flit appears the cycle after acceptance.
- RX FSM, states e_rx_idle, e_rx_recv and e_rx_out:
  - link_ready_o = ~reset_i & (state != e_rx_out).
  - Header accepted in e_rx_idle: store flit 0, latch len from the header. Next state is e_rx_out if len==0, else e_rx_recv.
  - e_rx_recv: store each accepted flit at the counter index; after flit len is accepted, go to e_rx_out.
  - Bits beyond the received flits read as zero; the buffer is cleared when each new header is accepted.
  - e_rx_out: pkt_v_o=1 and pkt_o/pkt_len_o held stable. On pkt_ready_i, return to e_rx_idle; the next header can be accepted in the following cycle.
- Length bound: pkt_len_i > max_num_flit_lp-1 is illegal. It is clamped to max_num_flit_lp-1, and a simulation-only assertion fires.
- Reset: both FSMs go idle and counters go to 0. link_v_o=0, pkt_v_o=0, pkt_ready_o=0, link_ready_o=0, pkt_o=0, pkt_len_o=0.
- Reset mid-packet drops all partial state; no flit is emitted in the cycle after reset deasserts.
- TX and RX are fully independent; simultaneous traffic in both directions is legal.

Optional Feature:
- Macro: BP_ME_WORMHOLE_LOCAL_BYPASS_EN.
- Defined: a TX packet with pkt_x_i==my_x_i && pkt_y_i==my_y_i bypasses the link.
  - It is accepted only when the RX FSM is e_rx_idle and no header is arriving on the link that cycle; the network header has priority.
  - It loads the RX buffer directly and appears on pkt_o with pkt_v_o=1 the next cycle; link_v_o stays 0.
  - Otherwise pkt_ready_o is held low for local-destination packets.
- Undefined: local packets traverse the link like any other.

Test Plan:
- Reset then idle: all outputs 0 during reset. One cycle after deassert, pkt_ready_o=1 and link_ready_o=1.
- TX pkt_len_i=8, payload=pattern 0xA5.., dest (2,3), link_ready_i=1 -> 9 consecutive flits. Flit0[11:0]=0x832; the rest match the packet slices.
- TX two back-to-back packets of len 0 and len 2 -> flits on cycles 1,2,3,4 with no bubble; pkt_ready_o high on cycles 0 and 1.
- RX 3-flit packet with link_v_i gaps and pkt_ready_i=0 for 5 cycles -> pkt_v_o held with stable data. link_ready_o=0 while pending, and the next header is accepted the cycle after pkt_ready_i.
- Reset asserted after flit 4 of 9 on both paths -> link_v_o and pkt_v_o drop; the next packet after reset is transferred intact.
- Bypass with macro, dest == (my_x_i,my_y_i) = (1,1), len 5 -> pkt_v_o=1 next cycle, link_v_o never high. Without the macro -> 6 flits appear on the link.
